// File: rtl/arb_rr4_ctrl_if.sv
// Handshake bundle between four requesters and the shared-resource arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface arb_rr4_ctrl_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_idx,
    input  busy,
    input  timeout
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_idx,
    output busy,
    output timeout
  );
endinterface

// File: rtl/arb_rr4_ctrl.sv
// Four-requester arbiter for one shared resource.
// Grants one requester at a time and holds the grant while its request stays high.
// A grant is released when the request drops, when enable drops, or when it has been held
// for HOLD_MAX cycles. Priority then moves on round-robin from the last granted index.
// Optional build macro ARB_FIXED_PRIO_EN: when defined, the highest requesting index always
// wins and the round-robin pointer is ignored; timeout behaviour is unchanged.
module arb_rr4_ctrl #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  arb_rr4_ctrl_if.slave      io_bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StGrant   = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_gnt_idx;
  logic             r_busy;
  logic             r_timeout;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [1:0]       r_ptr;

  logic [1:0]       w_win;
  logic             w_any;
  logic             w_start;
  logic             w_hold_lim;
  logic             w_req_held;

  assign w_any      = |io_bus.req;
  assign w_start    = io_bus.en && w_any;
  assign w_hold_lim = (r_hold_cnt == CNT_W'(HOLD_MAX - 1));
  assign w_req_held = io_bus.req[r_gnt_idx];

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: highest requesting index wins.
  always_comb begin
    w_win = 2'd0;
    if (io_bus.req[3])      w_win = 2'd3;
    else if (io_bus.req[2]) w_win = 2'd2;
    else if (io_bus.req[1]) w_win = 2'd1;
    else                    w_win = 2'd0;
  end
`else
  // Round-robin: search ptr+1, ptr+2, ptr+3, ptr and take the first set request.
  always_comb begin : rr_search
    logic       w_found;
    logic [1:0] w_cand;
    w_win   = r_ptr;
    w_found = 1'b0;
    w_cand  = r_ptr;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_found && io_bus.req[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end
`endif

  // Control FSM plus registered grant outputs; reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_gnt      <= 4'b0000;
      r_gnt_idx  <= 2'b00;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
      r_ptr      <= 2'b11;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        StIdle, StRelease: begin
          if (w_start) begin
            r_gnt      <= 4'b0001 << w_win;
            r_gnt_idx  <= w_win;
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= StGrant;
          end else begin
            r_state <= StIdle;
          end
        end
        StGrant: begin
          if (!w_req_held || !io_bus.en || w_hold_lim) begin
            // Timeout only when the limit alone forced the release.
            r_timeout <= w_req_held && io_bus.en;
            r_ptr     <= r_gnt_idx;
            r_gnt     <= 4'b0000;
            r_busy    <= 1'b0;
            r_state   <= StRelease;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_gnt   <= 4'b0000;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.gnt     = r_gnt;
  assign io_bus.gnt_idx = r_gnt_idx;
  assign io_bus.busy    = r_busy;
  assign io_bus.timeout = r_timeout;

endmodule
